// File: rtl/schmitt_scan_ctrl.sv
// schmitt_scan_ctrl: time-multiplexed debounce/hysteresis engine for slow inputs,
// one shared evaluator walking all channels per sample tick, with an event FIFO.
module schmitt_scan_ctrl #(
  parameter int p_channels = 8,
  parameter int p_scale    = 5,
  parameter int p_div      = 100,
  parameter int p_depth    = 4,
  localparam int cw = (p_channels > 1) ? $clog2(p_channels) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [p_channels-1:0] i_in,
  output logic [p_channels-1:0] o_level,
  output logic                  o_evt_valid,
  input  logic                  i_evt_ready,
  output logic [cw-1:0]         o_evt_chan,
  output logic                  o_evt_level,
  output logic                  o_overflow,
  input  logic                  i_clr_ovf
);
  localparam int kw = $clog2(p_scale + 1);
  localparam int pw = $clog2(p_div);
  localparam int aw = $clog2(p_depth);
  localparam logic [2:0] st_start = 3'd0, st_low = 3'd1, st_rise = 3'd2, st_high = 3'd3, st_fall = 3'd4;
  localparam logic [1:0] sc_idle = 2'd0, sc_snap = 2'd1, sc_scan = 2'd2;

  if (p_div < p_channels + 2) begin : g_bad_div
    $error("schmitt_scan_ctrl: p_div must be >= p_channels+2");
  end
  if (p_depth < 2 || (p_depth & (p_depth - 1)) != 0) begin : g_bad_depth
    $error("schmitt_scan_ctrl: p_depth must be a power of two >= 2");
  end

  logic [p_channels-1:0] sync1_q, sync2_q, snap_q, level_q;
  logic [pw-1:0] psc_q;
  logic [1:0] sc_q, sc_d;
  logic [cw-1:0] idx_q;
  logic [2:0] st_q [p_channels];
  logic [kw-1:0] cnt_q [p_channels];
  logic [2:0] st_d, cur;
  logic [kw-1:0] cnt_d, c;
  logic s, hi, pend, commit, tick, last, scanning;
  logic [cw-1:0] fc_q [p_depth];
  logic fl_q [p_depth];
  logic [aw-1:0] wr_q, rd_q;
  logic [aw:0] fill_q;
  logic ovf_q, push, pop, full, accept, drop;

  assign tick = i_en && (psc_q == pw'(p_div - 1));
  assign last = idx_q == cw'(p_channels - 1);
  assign scanning = sc_q == sc_scan;
  assign sc_d = (sc_q == sc_idle) ? (tick ? sc_snap : sc_idle) :
                (sc_q == sc_snap) ? sc_scan : (last ? sc_idle : sc_scan);

  // A sample disagreeing with the committed level either advances the pending
  // count or commits; an agreeing one always falls back to the stable state.
  always_comb begin
    s = snap_q[idx_q];
    cur = st_q[idx_q];
    c = cnt_q[idx_q];
    hi = (cur == st_high) || (cur == st_fall);
    pend = (cur == st_rise) || (cur == st_fall);
    commit = 1'b0;
    st_d = s ? st_high : st_low;
    cnt_d = '0;
    if (cur != st_start && s != hi) begin
      commit = pend ? (c == kw'(p_scale - 1)) : (p_scale == 1);
      st_d = commit ? (s ? st_high : st_low) : (hi ? st_fall : st_rise);
      cnt_d = commit ? '0 : c + 1'b1;
    end
  end

  assign push = scanning && commit;
  assign pop = o_evt_valid && i_evt_ready;
  assign full = fill_q == (aw + 1)'(p_depth);
  assign accept = push && (!full || pop);
  assign drop = push && full && !pop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      snap_q <= '0;
      level_q <= '0;
      psc_q <= '0;
      sc_q <= sc_idle;
      idx_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      fill_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < p_channels; i++) begin
        st_q[i] <= st_start;
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= i_in;
      sync2_q <= sync1_q;
      if (i_en) psc_q <= tick ? '0 : psc_q + 1'b1;
      sc_q <= sc_d;
      if (sc_q == sc_snap) begin
        snap_q <= sync2_q;
        idx_q <= '0;
      end
      if (scanning) begin
        st_q[idx_q] <= st_d;
        cnt_q[idx_q] <= cnt_d;
        level_q[idx_q] <= (st_d == st_high) || (st_d == st_fall);
        idx_q <= idx_q + 1'b1;
      end
      wr_q <= wr_q + aw'(accept);
      rd_q <= rd_q + aw'(pop);
      fill_q <= fill_q + (aw + 1)'(accept) - (aw + 1)'(pop);
      ovf_q <= drop || (ovf_q && !i_clr_ovf);
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      fc_q[wr_q] <= idx_q;
      fl_q[wr_q] <= s;
    end
  end

  assign o_level = level_q;
  assign o_evt_valid = fill_q != '0;
  assign o_evt_chan = o_evt_valid ? fc_q[rd_q] : '0;
  assign o_evt_level = o_evt_valid && fl_q[rd_q];
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_schmitt_scan_ctrl.sv
// tb_schmitt_scan_ctrl: randomized stimulus against a run-length debounce model
// with a bounded event queue and a cycle-level tick/pass schedule.
module tb_schmitt_scan_ctrl;
  localparam int N = 4, SC = 3, DIV = 8, D = 4;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, ready = 1'b1, clr = 1'b0;
  logic [N-1:0] in_v = 4'b0101;
  logic [N-1:0] o_level;
  logic o_evt_valid, o_evt_level, o_overflow;
  logic [1:0] o_evt_chan;
  int pass_cnt = 0, total = 0;

  schmitt_scan_ctrl #(.p_channels(N), .p_scale(SC), .p_div(DIV), .p_depth(D)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_in(in_v), .o_level(o_level),
    .o_evt_valid(o_evt_valid), .i_evt_ready(ready), .o_evt_chan(o_evt_chan),
    .o_evt_level(o_evt_level), .o_overflow(o_overflow), .i_clr_ovf(clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
  endtask

  bit m_lvl [N];
  bit m_init [N];
  int m_run [N];
  int m_q [$];
  bit m_ovf;
  int psc, ph;
  logic [N-1:0] h0, h1, h2, snap;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_lvl[i] = 0;
      m_init[i] = 0;
      m_run[i] = 0;
    end
    m_q.delete();
    m_ovf = 0;
    psc = 0;
    ph = -1;
    h0 = '0;
    h1 = '0;
    h2 = '0;
    snap = '0;
  endtask

  // One clock edge: input history shifts, head pops, pass schedule advances, tick fires.
  task automatic model_edge();
    bit pop, set, was_idle, sv;
    int ch;
    pop = ready && m_q.size() != 0;
    set = 0;
    was_idle = ph < 0;
    h2 = h1;
    h1 = h0;
    h0 = in_v;
    if (pop) void'(m_q.pop_front());
    if (ph == 0) begin
      snap = h2;
      ph = 1;
    end else if (ph > 0) begin
      ch = ph - 1;
      sv = snap[ch];
      if (!m_init[ch]) begin
        m_init[ch] = 1;
        m_lvl[ch] = sv;
      end else if (sv != m_lvl[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == SC) begin
          m_lvl[ch] = sv;
          m_run[ch] = 0;
          if (m_q.size() == D) set = 1;
          else m_q.push_back(ch * 2 + int'(sv));
        end
      end else m_run[ch] = 0;
      ph = (ch == N - 1) ? -1 : ph + 1;
    end
    if (en) begin
      if (psc == DIV - 1) begin
        psc = 0;
        if (was_idle) ph = 0;
      end else psc++;
    end
    m_ovf = set ? 1'b1 : (clr ? 1'b0 : m_ovf);
  endtask

  task automatic compare();
    logic [N-1:0] mlv;
    for (int i = 0; i < N; i++) mlv[i] = m_lvl[i];
    check("level", o_level, mlv);
    check("valid", o_evt_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("chan", o_evt_chan, m_q[0] / 2);
      check("evt_level", o_evt_level, m_q[0] % 2);
    end
    check("overflow", o_overflow, m_ovf);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n, input int flip_mod, input int rdy_pct, input int en_pct);
    int b;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (flip_mod > 0 && $urandom_range(flip_mod - 1) == 0) begin
        b = $urandom_range(N - 1);
        in_v[b] = ~in_v[b];
      end
      ready = $urandom_range(99) < rdy_pct;
      if (en_pct > 0 && en_pct < 100 && i % 16 == 0) en = $urandom_range(99) < en_pct;
      clr = 1'b0;
    end
  endtask

  task automatic wait_ph(input int target, input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < 4 * DIV && !found; i++) begin
      cyc();
      found = ph == target;
    end
    check(tag, found, 1);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    compare();
    rst_n = 1'b1;
    run(30, 0, 100, 0);
    run(600, 64, 50, 0);
    ready = 1'b0;
    in_v = ~in_v;
    run(40, 0, 0, 0);
    in_v = ~in_v;
    run(40, 0, 0, 0);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    run(200, 8, 30, 0);
    run(300, 48, 60, 0);
    run(600, 48, 50, 60);
    en = 1'b1;
    in_v = '1;
    run(60, 0, 50, 0);
    wait_ph(2, "scan_wait_rst");
    rst_n = 1'b0;
    #1;
    check("rst_level", o_level, 0);
    check("rst_valid", o_evt_valid, 0);
    check("rst_chan", o_evt_chan, 0);
    check("rst_evt_level", o_evt_level, 0);
    check("rst_overflow", o_overflow, 0);
    model_reset();
    in_v = 4'b0110;
    repeat (3) @(negedge clk);
    compare();
    rst_n = 1'b1;
    run(300, 40, 50, 0);
    wait_ph(2, "scan_wait_en");
    en = 1'b0;
    run(120, 6, 50, 0);
    en = 1'b1;
    run(200, 40, 50, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
